// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB2 bridge: each accepted single AHB transfer becomes one
// APB SETUP/ENABLE pair, with AHB wait states held while the APB cycle runs.
module ahb_apb_bridge #(
  parameter int unsigned NUM_SLAVES  = 4,
  parameter logic [3:0]  BASE_NIBBLE = 4'h8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic                  HREADYin,
  input  logic [31:0]           HADDR,
  input  logic [2:0]            HBURST,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  output logic                  HREADYout,
  output logic [1:0]            HRESP,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [31:0]           PADDR,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWwait  = 2'd1;
  localparam logic [1:0] StSetup  = 2'd2;
  localparam logic [1:0] StEnable = 2'd3;

  localparam logic [4:0] NumSlavesW = 5'(NUM_SLAVES);

  logic [1:0]  state_q, state_d;
  logic [31:0] paddr_q, paddr_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [3:0]  idx_q, idx_d;

  logic accept;
  logic apb_active;

  // HBURST/HSIZE are deliberately ignored: every transfer is a 32-bit single.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HSIZE};

  assign accept = HREADYin && HTRANS[1] && (HADDR[31:28] == BASE_NIBBLE) &&
                  ({1'b0, HADDR[27:24]} < NumSlavesW);

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    idx_d    = idx_q;
    case (state_q)
      // Address phases are only sampled while HREADYout is high.
      StIdle, StEnable: begin
        if (accept) begin
          state_d  = HWRITE ? StWwait : StSetup;
          paddr_d  = HADDR;
          pwrite_d = HWRITE;
          idx_d    = HADDR[27:24];
        end else begin
          state_d = StIdle;
        end
      end
      StWwait: begin
        pwdata_d = HWDATA;
        state_d  = StSetup;
      end
      StSetup: state_d = StEnable;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= StIdle;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      idx_q    <= idx_d;
    end
  end

  assign apb_active = (state_q == StSetup) || (state_q == StEnable);

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_psel
    assign PSEL[i] = apb_active && (idx_q == 4'(i));
  end

  assign PENABLE   = (state_q == StEnable);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign HREADYout = (state_q == StIdle) || (state_q == StEnable);
  assign HRESP     = 2'b00;
  assign HRDATA    = ((state_q == StEnable) && !pwrite_q) ? PRDATA : 32'h0;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Self-checking bench for ahb_apb_bridge: APB transfers are checked against a
// scoreboard queue filled as AHB stimulus is driven; tasks check cycle timing.
module tb_ahb_apb_bridge;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic        HREADYin = 1'b1;
  logic [31:0] HADDR = 32'h0;
  logic [2:0]  HBURST = 3'b000;
  logic [2:0]  HSIZE = 3'b010;
  logic [31:0] HWDATA = 32'h0;
  logic [31:0] HRDATA;
  logic        HREADYout;
  logic [1:0]  HRESP;
  logic [3:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = 32'h0;

  typedef struct {
    logic [3:0]  psel;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] hrdata;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  ahb_apb_bridge #(
    .NUM_SLAVES (4),
    .BASE_NIBBLE(4'h8)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HREADYin (HREADYin),
    .HADDR    (HADDR),
    .HBURST   (HBURST),
    .HSIZE    (HSIZE),
    .HWDATA   (HWDATA),
    .HRDATA   (HRDATA),
    .HREADYout(HREADYout),
    .HRESP    (HRESP),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA)
  );

  always #5 HCLK = ~HCLK;

  // Scoreboard consumer: every APB ENABLE cycle must match the oldest expectation.
  always @(negedge HCLK) begin
    exp_t e;
    if (HRESETn && PENABLE && (PSEL != 4'b0000)) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_underflow: APB enable with PSEL=%b PADDR=%h, none expected", PSEL, PADDR);
      end else begin
        e = sb.pop_front();
        vectors += 4;
        if (PSEL !== e.psel) begin
          miscompares++;
          $display("FAIL sb_psel: got %b expected %b", PSEL, e.psel);
        end
        if (PADDR !== e.paddr) begin
          miscompares++;
          $display("FAIL sb_paddr: got %h expected %h", PADDR, e.paddr);
        end
        if (PWRITE !== e.pwrite) begin
          miscompares++;
          $display("FAIL sb_pwrite: got %b expected %b", PWRITE, e.pwrite);
        end
        if (HREADYout !== 1'b1) begin
          miscompares++;
          $display("FAIL sb_hready_enable: got %b expected 1", HREADYout);
        end
        if (e.pwrite) begin
          if (PWDATA !== e.pwdata) begin
            miscompares++;
            $display("FAIL sb_pwdata: got %h expected %h", PWDATA, e.pwdata);
          end
        end else begin
          if (HRDATA !== e.hrdata) begin
            miscompares++;
            $display("FAIL sb_hrdata: got %h expected %h", HRDATA, e.hrdata);
          end
        end
      end
    end
  end

  // Drives one single transfer, returns at the falling edge of its ENABLE cycle.
  task automatic bus_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [31:0] rdata, output int waits,
                          output logic [3:0] setup_psel, output bit ok);
    exp_t e;
    e.psel   = 4'b0001 << addr[27:24];
    e.paddr  = addr;
    e.pwrite = wr;
    e.pwdata = wdata;
    e.hrdata = wr ? 32'h0 : rdata;
    sb.push_back(e);
    HTRANS   = 2'b10;
    HADDR    = addr;
    HWRITE   = wr;
    HREADYin = 1'b1;
    PRDATA   = rdata;
    @(posedge HCLK); #1;
    HTRANS     = 2'b00;
    HADDR      = $urandom;
    HWDATA     = wdata;
    waits      = 0;
    setup_psel = 4'b0000;
    ok         = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge HCLK);
      if (HREADYout) begin
        ok = 1'b1;
        break;
      end
      if (PSEL != 4'b0000 && !PENABLE) setup_psel = PSEL;
      waits++;
      @(posedge HCLK); #1;
      HWDATA = 32'h0BAD_F00D;
    end
  endtask

  task automatic test_reset();
    HRESETn  = 1'b0;
    HTRANS   = 2'($urandom);
    HWRITE   = 1'($urandom);
    HREADYin = 1'($urandom);
    HADDR    = $urandom;
    HWDATA   = $urandom;
    HBURST   = 3'($urandom);
    HSIZE    = 3'($urandom);
    PRDATA   = $urandom;
    repeat (3) @(posedge HCLK);
    #1;
    vectors += 8;
    if (HREADYout !== 1'b1) begin miscompares++; $display("FAIL rst_hready: got %b expected 1", HREADYout); end
    if (HRESP !== 2'b00) begin miscompares++; $display("FAIL rst_hresp: got %b expected 00", HRESP); end
    if (HRDATA !== 32'h0) begin miscompares++; $display("FAIL rst_hrdata: got %h expected 0", HRDATA); end
    if (PSEL !== 4'b0000) begin miscompares++; $display("FAIL rst_psel: got %b expected 0000", PSEL); end
    if (PENABLE !== 1'b0) begin miscompares++; $display("FAIL rst_penable: got %b expected 0", PENABLE); end
    if (PWRITE !== 1'b0) begin miscompares++; $display("FAIL rst_pwrite: got %b expected 0", PWRITE); end
    if (PADDR !== 32'h0) begin miscompares++; $display("FAIL rst_paddr: got %h expected 0", PADDR); end
    if (PWDATA !== 32'h0) begin miscompares++; $display("FAIL rst_pwdata: got %h expected 0", PWDATA); end
    HTRANS   = 2'b00;
    HREADYin = 1'b1;
    HADDR    = 32'h8000_0000;
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      vectors++;
      if (PSEL !== 4'b0000 || HREADYout !== 1'b1) begin
        miscompares++;
        $display("FAIL rst_idle_%0d: got PSEL=%b HREADYout=%b expected 0000/1", i, PSEL, HREADYout);
      end
    end
  endtask

  task automatic test_single_write();
    int w; logic [3:0] sp; bit ok;
    bus_xfer(32'h8100_0010, 1'b1, 32'hDEAD_BEEF, $urandom, w, sp, ok);
    vectors += 3;
    if (!ok) begin miscompares++; $display("FAIL wr_timeout: got no HREADYout, expected ENABLE"); end
    if (w != 2) begin miscompares++; $display("FAIL wr_waits: got %0d expected 2", w); end
    if (sp !== 4'b0010) begin miscompares++; $display("FAIL wr_setup_psel: got %b expected 0010", sp); end
    @(posedge HCLK); #1;
    @(negedge HCLK);
    vectors += 2;
    if (PSEL !== 4'b0000 || HREADYout !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_after_idle: got PSEL=%b HREADYout=%b expected 0000/1", PSEL, HREADYout);
    end
    if (PADDR !== 32'h8100_0010 || PWDATA !== 32'hDEAD_BEEF || PWRITE !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_hold: got %h/%h/%b expected 81000010/deadbeef/1", PADDR, PWDATA, PWRITE);
    end
  endtask

  task automatic test_single_read();
    int w; logic [3:0] sp; bit ok;
    bus_xfer(32'h8300_0004, 1'b0, 32'h0, 32'h1234_5678, w, sp, ok);
    vectors += 3;
    if (!ok) begin miscompares++; $display("FAIL rd_timeout: got no HREADYout, expected ENABLE"); end
    if (w != 1) begin miscompares++; $display("FAIL rd_waits: got %0d expected 1", w); end
    if (sp !== 4'b1000) begin miscompares++; $display("FAIL rd_setup_psel: got %b expected 1000", sp); end
    @(posedge HCLK); #1;
    @(negedge HCLK);
    vectors++;
    if (HRDATA !== 32'h0) begin
      miscompares++;
      $display("FAIL rd_hrdata_idle: got %h expected 0", HRDATA);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e1, e2;
    int total; int phase; bit ok;
    e1 = '{psel: 4'b0001, paddr: 32'h8000_0000, pwrite: 1'b1, pwdata: 32'hA5A5_0001, hrdata: 32'h0};
    e2 = '{psel: 4'b0100, paddr: 32'h8200_0008, pwrite: 1'b0, pwdata: 32'hA5A5_0001,
           hrdata: 32'hCAFE_0042};
    sb.push_back(e1);
    sb.push_back(e2);
    HTRANS = 2'b10; HADDR = 32'h8000_0000; HWRITE = 1'b1; HREADYin = 1'b1;
    @(posedge HCLK); #1;
    HTRANS = 2'b00; HWDATA = 32'hA5A5_0001;
    total = 0; phase = 0; ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge HCLK);
      total++;
      if (HREADYout) begin
        if (phase == 0) begin
          HTRANS = 2'b10; HADDR = 32'h8200_0008; HWRITE = 1'b0; PRDATA = 32'hCAFE_0042;
          phase = 1;
        end else begin
          ok = 1'b1;
          break;
        end
      end else if (phase == 1) begin
        vectors++;
        if (PSEL !== 4'b0100 || PENABLE !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_setup: got PSEL=%b PENABLE=%b expected 0100/0", PSEL, PENABLE);
        end
        phase = 2;
      end
      @(posedge HCLK); #1;
      HTRANS = 2'b00;
      if (total == 1) HWDATA = 32'h0BAD_F00D;
    end
    vectors += 2;
    if (!ok) begin miscompares++; $display("FAIL b2b_timeout: got no second ENABLE, expected one"); end
    if (total != 5) begin miscompares++; $display("FAIL b2b_cycles: got %0d expected 5", total); end
    @(posedge HCLK); #1;
  endtask

  task automatic test_ignored();
    logic [1:0]  tr [4] = '{2'b01, 2'b10, 2'b10, 2'b10};
    logic [31:0] ad [4] = '{32'h8000_0000, 32'h9000_0000, 32'h8500_0000, 32'h8000_0000};
    logic        rdy[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      HTRANS = tr[k]; HADDR = ad[k]; HREADYin = rdy[k]; HWRITE = 1'($urandom);
      for (int i = 0; i < 3; i++) begin
        @(negedge HCLK);
        vectors++;
        if (PSEL !== 4'b0000 || HREADYout !== 1'b1) begin
          miscompares++;
          $display("FAIL ign_%0d_%0d: got PSEL=%b HREADYout=%b expected 0000/1", k, i, PSEL,
                   HREADYout);
        end
        @(posedge HCLK); #1;
        HTRANS = 2'b00; HREADYin = 1'b1;
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int w; logic [3:0] sp; bit ok;
    HTRANS = 2'b10; HADDR = 32'h8100_0020; HWRITE = 1'b1; HREADYin = 1'b1;
    @(posedge HCLK); #1;
    HTRANS = 2'b00; HWDATA = 32'h1357_9BDF;
    @(posedge HCLK); #1;
    vectors++;
    if (PSEL !== 4'b0010) begin
      miscompares++;
      $display("FAIL mid_pre_setup: got PSEL=%b expected 0010", PSEL);
    end
    #2;
    HRESETn = 1'b0;
    #1;
    vectors += 4;
    if (PSEL !== 4'b0000) begin miscompares++; $display("FAIL mid_psel: got %b expected 0000", PSEL); end
    if (PENABLE !== 1'b0) begin miscompares++; $display("FAIL mid_penable: got %b expected 0", PENABLE); end
    if (PWDATA !== 32'h0) begin miscompares++; $display("FAIL mid_pwdata: got %h expected 0", PWDATA); end
    if (HREADYout !== 1'b1) begin miscompares++; $display("FAIL mid_hready: got %b expected 1", HREADYout); end
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    bus_xfer(32'h8200_0004, 1'b1, 32'h2468_ACE0, $urandom, w, sp, ok);
    vectors += 3;
    if (!ok) begin miscompares++; $display("FAIL mid_post_timeout: got no ENABLE, expected one"); end
    if (w != 2) begin miscompares++; $display("FAIL mid_post_waits: got %0d expected 2", w); end
    if (sp !== 4'b0100) begin miscompares++; $display("FAIL mid_post_psel: got %b expected 0100", sp); end
    @(posedge HCLK); #1;
  endtask

  task automatic test_random();
    int w; logic [3:0] sp; bit ok;
    logic [31:0] addr; logic wr;
    for (int k = 0; k < 6; k++) begin
      addr = {4'h8, 4'($urandom_range(0, 3)), 22'($urandom), 2'b00};
      wr   = 1'($urandom);
      bus_xfer(addr, wr, $urandom, $urandom, w, sp, ok);
      vectors += 2;
      if (!ok || w != (wr ? 2 : 1)) begin
        miscompares++;
        $display("FAIL rand_%0d_waits: got ok=%0d waits=%0d expected ok=1 waits=%0d", k, ok, w,
                 wr ? 2 : 1);
      end
      if (sp !== (4'b0001 << addr[27:24])) begin
        miscompares++;
        $display("FAIL rand_%0d_psel: got %b expected %b", k, sp, 4'b0001 << addr[27:24]);
      end
      @(posedge HCLK); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_ignored();
    test_reset_mid_write();
    test_random();
    repeat (2) @(negedge HCLK);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d pending entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
